// File: rtl/phase_timing_pkg.sv
// Shared types, default phase durations and the phase-to-duration lookup for the phase timing checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package phase_timing_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        EARLY   = 2'd1,
        LATE    = 2'd2,
        TIMEOUT = 2'd3
    } err_code_t;

    localparam int          DEF_CNT_W  = 21;
    localparam int unsigned DEF_D0     = 2000000;
    localparam int unsigned DEF_D1     = 1950;
    localparam int unsigned DEF_D2     = 1850;
    localparam int unsigned DEF_D3     = 1850;
    localparam int unsigned DEF_D4     = 76500;
    localparam int unsigned DEF_TOL    = 0;
    localparam logic [2:0]  LAST_PHASE = 3'd4;

    // Expected interval of phase k; indices above the last phase never occur.
    function automatic int unsigned phase_dur(input logic [2:0] k,
                                              input int unsigned d0,
                                              input int unsigned d1,
                                              input int unsigned d2,
                                              input int unsigned d3,
                                              input int unsigned d4);
        case (k)
            3'd0:    return d0;
            3'd1:    return d1;
            3'd2:    return d2;
            3'd3:    return d3;
            default: return d4;
        endcase
    endfunction

endpackage

// File: rtl/interval_counter.sv
// Interval counter with registered bound compares for the phase timing checker.
// Latency: count and compare flags reflect the load/inc decision one cycle later.
// Backpressure: none; controls are acted on every cycle.
// Ports: clk/rst (sync, active-high); load (count <= 1), inc (count + 1), else hold;
//        min_bound/max1_bound are the bounds for the count being loaded this cycle;
//        cnt = current count, lt_min = cnt < min_bound, eq_max1 = cnt == max1_bound.
module interval_counter #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] min_bound,
    input  logic [CNT_W-1:0] max1_bound,
    output logic [CNT_W-1:0] cnt,
    output logic             lt_min,
    output logic             eq_max1
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             lt_min_d, lt_min_q;
    logic             eq_max1_d, eq_max1_q;

    // Compares run against the next count so the flags line up with cnt_q
    // on the edge where the owner samples them.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(1);
        end else if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        lt_min_d  = (cnt_d < min_bound);
        eq_max1_d = (cnt_d == max1_bound);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            lt_min_q  <= 1'b0;
            eq_max1_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lt_min_q  <= lt_min_d;
            eq_max1_q <= eq_max1_d;
        end
    end

    assign cnt     = cnt_q;
    assign lt_min  = lt_min_q;
    assign eq_max1 = eq_max1_q;

endmodule

// File: rtl/phase_timing_checker.sv
// Monitors the 5-phase READY/TICK sequence and checks each phase interval against Dk +/- TOL.
// Latency: all outputs registered, valid the cycle after the deciding edge.
// Backpressure: none; START/TICK are strobes that are always accepted.
// Ports: CLK, RST (sync, active-high), START (arm, phase 0 begins), TICK (end of phase);
//        BUSY (measuring), PHASE (0..4), PHASE_OK (1-cycle pass pulse), SEQ_DONE/ERR (sticky),
//        ERR_CODE (none/early/late/timeout), ERR_PHASE, MEAS (last measured interval).
module phase_timing_checker
    import phase_timing_pkg::*;
#(
    parameter int          CNT_W = DEF_CNT_W,
    parameter int unsigned D0    = DEF_D0,
    parameter int unsigned D1    = DEF_D1,
    parameter int unsigned D2    = DEF_D2,
    parameter int unsigned D3    = DEF_D3,
    parameter int unsigned D4    = DEF_D4,
    parameter int unsigned TOL   = DEF_TOL
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             TICK,
    output logic             BUSY,
    output logic [2:0]       PHASE,
    output logic             PHASE_OK,
    output logic             SEQ_DONE,
    output logic             ERR,
    output logic [1:0]       ERR_CODE,
    output logic [2:0]       ERR_PHASE,
    output logic [CNT_W-1:0] MEAS
);

    localparam int unsigned MAX_D01 = (D0 > D1) ? D0 : D1;
    localparam int unsigned MAX_D23 = (D2 > D3) ? D2 : D3;
    localparam int unsigned MAX_DA  = (MAX_D01 > MAX_D23) ? MAX_D01 : MAX_D23;
    localparam int unsigned MAX_D   = (MAX_DA > D4) ? MAX_DA : D4;

    // The timeout bound must be representable so the counter can never wrap.
    if ((longint'(1) << CNT_W) <= longint'(MAX_D) + longint'(TOL) + longint'(1)) begin : g_cnt_w_check
        $error("CNT_W too narrow for the longest phase bound");
    end

    state_t           state_d, state_q;
    logic [2:0]       phase_d, phase_q;
    logic             phase_ok_d, phase_ok_q;
    logic             seq_done_d, seq_done_q;
    logic             err_d, err_q;
    err_code_t        err_code_d, err_code_q;
    logic [2:0]       err_phase_d, err_phase_q;
    logic [CNT_W-1:0] meas_d, meas_q;

    logic             measuring;
    logic             cnt_load, cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             lt_min, eq_max1;
    int unsigned      dur_next;
    logic [CNT_W-1:0] min_bound, max1_bound;

    assign measuring = (state_q == MEASURE);
    // Every event (START or an in-sequence TICK) starts a new interval at 1.
    assign cnt_load  = START | (measuring & TICK);
    // Freeze at the timeout bound; the FSM leaves MEASURE on that edge anyway.
    assign cnt_inc   = measuring & ~eq_max1;

    // Bounds follow the phase that the loaded count will belong to.
    always_comb begin
        dur_next   = phase_dur(phase_d, D0, D1, D2, D3, D4);
        min_bound  = (dur_next > TOL) ? CNT_W'(dur_next - TOL) : '0;
        max1_bound = CNT_W'(dur_next + TOL + 32'd1);
    end

    interval_counter #(
        .CNT_W (CNT_W)
    ) u_interval_counter (
        .clk        (CLK),
        .rst        (RST),
        .load       (cnt_load),
        .inc        (cnt_inc),
        .min_bound  (min_bound),
        .max1_bound (max1_bound),
        .cnt        (cnt),
        .lt_min     (lt_min),
        .eq_max1    (eq_max1)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        phase_ok_d  = 1'b0;
        seq_done_d  = seq_done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_phase_d = err_phase_q;
        meas_d      = meas_q;

        if (START) begin
            state_d     = MEASURE;
            phase_d     = 3'd0;
            seq_done_d  = 1'b0;
            err_d       = 1'b0;
            err_code_d  = NONE;
            err_phase_d = 3'd0;
            meas_d      = '0;
        end else if (measuring) begin
            if (TICK) begin
                meas_d = cnt;
                if (lt_min) begin
                    state_d     = FAULT;
                    err_d       = 1'b1;
                    err_code_d  = EARLY;
                    err_phase_d = phase_q;
                end else if (eq_max1) begin
                    state_d     = FAULT;
                    err_d       = 1'b1;
                    err_code_d  = LATE;
                    err_phase_d = phase_q;
                end else begin
                    phase_ok_d = 1'b1;
                    if (phase_q == LAST_PHASE) begin
                        state_d    = DONE;
                        seq_done_d = 1'b1;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
            end else if (eq_max1) begin
                state_d     = FAULT;
                err_d       = 1'b1;
                err_code_d  = TIMEOUT;
                err_phase_d = phase_q;
                meas_d      = cnt;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            phase_q     <= 3'd0;
            phase_ok_q  <= 1'b0;
            seq_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= NONE;
            err_phase_q <= 3'd0;
            meas_q      <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            phase_ok_q  <= phase_ok_d;
            seq_done_q  <= seq_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_phase_q <= err_phase_d;
            meas_q      <= meas_d;
        end
    end

    assign BUSY      = measuring;
    assign PHASE     = phase_q;
    assign PHASE_OK  = phase_ok_q;
    assign SEQ_DONE  = seq_done_q;
    assign ERR       = err_q;
    assign ERR_CODE  = err_code_q;
    assign ERR_PHASE = err_phase_q;
    assign MEAS      = meas_q;

endmodule

// File: tb/tb_phase_timing_checker.sv
// Bench for phase_timing_checker: table of {gap, inputs, expected outputs} plus hand sequences.
// Latency: each vector is checked 1 ns after the edge that samples its inputs.
// Backpressure: n/a.
module tb_phase_timing_checker;

    localparam int TW = 8;

    typedef struct packed {
        logic          busy;
        logic [2:0]    phase;
        logic          ok;
        logic          done;
        logic          err;
        logic [1:0]    code;
        logic [2:0]    ephase;
        logic [TW-1:0] meas;
    } obs_t;

    typedef struct {
        int   gap;   // idle edges before the event edge; interval = gap + 1
        logic rst;
        logic start;
        logic tick;
        obs_t exp;
    } vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic a_rst, a_start, a_tick;
    logic a_busy, a_ok, a_done, a_err;
    logic [2:0] a_phase, a_ephase;
    logic [1:0] a_code;
    logic [TW-1:0] a_meas;

    logic z_rst, z_start, z_tick;
    logic z_busy, z_ok, z_done, z_err;
    logic [2:0] z_phase, z_ephase;
    logic [1:0] z_code;
    logic [TW-1:0] z_meas;

    phase_timing_checker #(
        .CNT_W(TW), .D0(20), .D1(8), .D2(6), .D3(6), .D4(12), .TOL(1)
    ) dut (
        .CLK(CLK), .RST(a_rst), .START(a_start), .TICK(a_tick),
        .BUSY(a_busy), .PHASE(a_phase), .PHASE_OK(a_ok), .SEQ_DONE(a_done),
        .ERR(a_err), .ERR_CODE(a_code), .ERR_PHASE(a_ephase), .MEAS(a_meas)
    );

    // Zero-tolerance instance for the exact-bound corner cases.
    phase_timing_checker #(
        .CNT_W(TW), .D0(10), .D1(4), .D2(4), .D3(4), .D4(4), .TOL(0)
    ) dut_z (
        .CLK(CLK), .RST(z_rst), .START(z_start), .TICK(z_tick),
        .BUSY(z_busy), .PHASE(z_phase), .PHASE_OK(z_ok), .SEQ_DONE(z_done),
        .ERR(z_err), .ERR_CODE(z_code), .ERR_PHASE(z_ephase), .MEAS(z_meas)
    );

    obs_t a_obs, z_obs;
    assign a_obs = {a_busy, a_phase, a_ok, a_done, a_err, a_code, a_ephase, a_meas};
    assign z_obs = {z_busy, z_phase, z_ok, z_done, z_err, z_code, z_ephase, z_meas};

    int   n_chk = 0;
    int   n_fail = 0;
    int   ok_seen = 0;
    int   ok_exp = 0;
    obs_t sb[$];
    vec_t tbl[$];

    always @(negedge CLK) if (a_ok === 1'b1) ok_seen++;

    function automatic vec_t v(input int gap, input logic r, input logic s, input logic t,
                               input logic b, input int ph, input logic ok, input logic d,
                               input logic e, input int c, input int ep, input int m);
        vec_t x;
        x.gap = gap; x.rst = r; x.start = s; x.tick = t;
        x.exp.busy = b;        x.exp.phase = 3'(ph);   x.exp.ok = ok;
        x.exp.done = d;        x.exp.err = e;          x.exp.code = 2'(c);
        x.exp.ephase = 3'(ep); x.exp.meas = TW'(m);
        return x;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("busy=%0d phase=%0d ok=%0d done=%0d err=%0d code=%0d ephase=%0d meas=%0d",
                         o.busy, o.phase, o.ok, o.done, o.err, o.code, o.ephase, o.meas);
    endfunction

    task automatic run_vec(input bit on_z, input vec_t x, input string name);
        obs_t got, want;
        repeat (x.gap) begin @(posedge CLK); #1; end
        if (on_z) {z_rst, z_start, z_tick} = {x.rst, x.start, x.tick};
        else      {a_rst, a_start, a_tick} = {x.rst, x.start, x.tick};
        sb.push_back(x.exp);
        @(posedge CLK); #1;
        {a_rst, a_start, a_tick} = 3'b000;
        {z_rst, z_start, z_tick} = 3'b000;
        got  = on_z ? z_obs : a_obs;
        want = sb.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(want));
        end
    endtask

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_tick = 1'b0;
        z_rst = 1'b1; z_start = 1'b0; z_tick = 1'b0;

        //                 gap r s t  busy ph ok dn er cd ep meas
        tbl.push_back(v( 2, 1,0,0,  0, 0, 0, 0, 0, 0, 0,  0)); // reset state
        // nominal 20,8,6,6,12
        tbl.push_back(v( 2, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(19, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 20));
        tbl.push_back(v( 7, 0,0,1,  1, 2, 1, 0, 0, 0, 0,  8));
        tbl.push_back(v( 5, 0,0,1,  1, 3, 1, 0, 0, 0, 0,  6));
        tbl.push_back(v( 5, 0,0,1,  1, 4, 1, 0, 0, 0, 0,  6));
        tbl.push_back(v(11, 0,0,1,  0, 4, 1, 1, 0, 0, 0, 12));
        tbl.push_back(v( 0, 0,0,0,  0, 4, 0, 1, 0, 0, 0, 12)); // PHASE_OK is one cycle
        tbl.push_back(v( 3, 0,0,1,  0, 4, 0, 1, 0, 0, 0, 12)); // TICK in DONE ignored
        // tolerance edges 19,9,5,7,11
        tbl.push_back(v( 2, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(18, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 19));
        tbl.push_back(v( 8, 0,0,1,  1, 2, 1, 0, 0, 0, 0,  9));
        tbl.push_back(v( 4, 0,0,1,  1, 3, 1, 0, 0, 0, 0,  5));
        tbl.push_back(v( 6, 0,0,1,  1, 4, 1, 0, 0, 0, 0,  7));
        tbl.push_back(v(10, 0,0,1,  0, 4, 1, 1, 0, 0, 0, 11));
        // phase-1 interval 6 is below 8-1 -> EARLY
        tbl.push_back(v( 1, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(19, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 20));
        tbl.push_back(v( 5, 0,0,1,  0, 1, 0, 0, 1, 1, 1,  6));
        tbl.push_back(v( 3, 0,0,1,  0, 1, 0, 0, 1, 1, 1,  6)); // TICK in FAULT ignored
        // missing TICK in phase 2 -> TIMEOUT on edge 8, not 7
        tbl.push_back(v( 1, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(19, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 20));
        tbl.push_back(v( 7, 0,0,1,  1, 2, 1, 0, 0, 0, 0,  8));
        tbl.push_back(v( 6, 0,0,0,  1, 2, 0, 0, 0, 0, 0,  8));
        tbl.push_back(v( 0, 0,0,0,  0, 2, 0, 0, 1, 3, 2,  8));
        // TICK exactly at interval 8 in phase 2 -> LATE
        tbl.push_back(v( 1, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(19, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 20));
        tbl.push_back(v( 7, 0,0,1,  1, 2, 1, 0, 0, 0, 0,  8));
        tbl.push_back(v( 7, 0,0,1,  0, 2, 0, 0, 1, 2, 2,  8));
        // START with TICK mid-phase 3 -> restart, then a full phase 0
        tbl.push_back(v( 1, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(19, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 20));
        tbl.push_back(v( 7, 0,0,1,  1, 2, 1, 0, 0, 0, 0,  8));
        tbl.push_back(v( 5, 0,0,1,  1, 3, 1, 0, 0, 0, 0,  6));
        tbl.push_back(v( 2, 0,1,1,  1, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(19, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 20));
        tbl.push_back(v( 7, 0,0,1,  1, 2, 1, 0, 0, 0, 0,  8));
        // RST in phase 2 (START on that edge ignored), TICKs ignored, then START works
        tbl.push_back(v( 2, 1,1,0,  0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v( 3, 0,0,1,  0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(19, 0,0,1,  0, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v( 2, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0));
        tbl.push_back(v(19, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 20));

        foreach (tbl[i]) begin
            if (tbl[i].exp.ok) ok_exp++;
            run_vec(1'b0, tbl[i], $sformatf("vec%0d", i));
        end

        @(negedge CLK); #1;
        n_chk++;
        if (ok_seen != ok_exp) begin
            n_fail++;
            $display("FAIL phase_ok_count: got %0d pulses, expected %0d", ok_seen, ok_exp);
        end

        // Zero tolerance: exact bounds, one below -> EARLY, one above -> LATE.
        run_vec(1'b1, v( 2, 1,0,0,  0, 0, 0, 0, 0, 0, 0,  0), "z_reset");
        run_vec(1'b1, v( 1, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0), "z_start1");
        run_vec(1'b1, v( 9, 0,0,1,  1, 1, 1, 0, 0, 0, 0, 10), "z_exact_p0");
        run_vec(1'b1, v( 4, 0,0,1,  0, 1, 0, 0, 1, 2, 1,  5), "z_late_p1");
        run_vec(1'b1, v( 1, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0), "z_start2");
        run_vec(1'b1, v( 8, 0,0,1,  0, 0, 0, 0, 1, 1, 0,  9), "z_early_p0");
        run_vec(1'b1, v( 1, 0,1,0,  1, 0, 0, 0, 0, 0, 0,  0), "z_start3");
        run_vec(1'b1, v(10, 0,0,1,  0, 0, 0, 0, 1, 2, 0, 11), "z_late_p0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
